// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 clock-step controller: step-source modes
// and debounce FSM states.
package td4_pkg;

  localparam logic [1:0] MODE_SLOW   = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;
  localparam logic [1:0] MODE_HALT   = 2'b11;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'b00,
    DB_PRESS_CHK = 2'b01,
    DB_PRESSED   = 2'b10,
    DB_REL_CHK   = 2'b11
  } db_state_t;

  // Debounced level is high once a press is accepted and until the release
  // has been qualified.
  function automatic logic db_level(input db_state_t s);
    return (s == DB_PRESSED) || (s == DB_REL_CHK);
  endfunction

endpackage

// File: rtl/td4_debounce.sv
// Button conditioner: two-flop synchronizer followed by a press/release
// qualification FSM. Emits one press_evt per accepted press.
module td4_debounce
  import td4_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_db,
  output logic press_evt
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Counter value one short of DB_CYCLES: the sample that would bring the
  // count to DB_CYCLES is the one that completes qualification.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic      sync_p0;
  logic      btn_s;
  db_state_t state;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_p0 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      btn_s   <= sync_p0;
    end
  end

  // Debounce FSM with registered btn_db and single-cycle press_evt.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= DB_IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
      btn_db    <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      btn_db    <= db_level(state);
      case (state)
        DB_IDLE: begin
          if (btn_s) begin
            state <= DB_PRESS_CHK;
            cnt   <= CNT_ONE;
          end
        end
        DB_PRESS_CHK: begin
          if (!btn_s) begin
            state <= DB_IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= DB_PRESSED;
            cnt       <= cnt + 1'b1;
            press_evt <= 1'b1;
            btn_db    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (!btn_s) begin
            state <= DB_REL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        DB_REL_CHK: begin
          if (btn_s) begin
            state <= DB_PRESSED;
          end else if (cnt == CNT_LAST) begin
            state  <= DB_IDLE;
            cnt    <= cnt + 1'b1;
            btn_db <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/td4_step_ctrl.sv
// Clock-step controller for the TD4 core: picks the step source, drops any
// pulse that lands on a mode change, and issues one cpu_en per step event
// together with a wrap-around step count.
module td4_step_ctrl
  import td4_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en_slow,
  input  logic             en_fast,
  input  logic [1:0]       mode,
  input  logic             btn_raw,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             btn_db
);

  logic [1:0] mode_q;
  logic       chg;
  logic       press_evt;
  logic       req_p0;
  logic       cpu_en_p1;

  td4_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .clr      (clr),
    .btn_raw  (btn_raw),
    .btn_db   (btn_db),
    .press_evt(press_evt)
  );

  // Mode register; a difference against the live input marks a switch cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q <= MODE_SLOW;
    end else begin
      mode_q <= mode;
    end
  end

  assign chg = (mode != mode_q);

  // Source select from the registered mode; switch cycles are dropped.
  always_comb begin
    req_p0 = 1'b0;
    case (mode_q)
      MODE_SLOW:   req_p0 = en_slow;
      MODE_FAST:   req_p0 = en_fast;
      MODE_MANUAL: req_p0 = press_evt;
      MODE_HALT:   req_p0 = 1'b0;
      default:     req_p0 = 1'b0;
    endcase
    if (chg) begin
      req_p0 = 1'b0;
    end
  end

  // ---- stage p0 -> p1: registered clock-enable and step counter ----
  always_ff @(posedge clk) begin
    if (clr) begin
      cpu_en_p1 <= 1'b0;
      step_cnt  <= '0;
    end else begin
      cpu_en_p1 <= req_p0;
      if (cpu_en_p1) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign cpu_en = cpu_en_p1;

endmodule

// File: tb/tb_td4_step_ctrl.sv
// Directed bench for td4_step_ctrl with DB_CYCLES=4, CNT_W=4. Each tick
// drives one cycle of inputs, queues the expected cpu_en for that cycle,
// and compares it after the clock edge.
module tb_td4_step_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       en_slow;
  logic       en_fast;
  logic [1:0] mode;
  logic       btn_raw;
  logic       cpu_en;
  logic [3:0] step_cnt;
  logic       btn_db;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  td4_step_ctrl #(
    .DB_CYCLES(4),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en_slow (en_slow),
    .en_fast (en_fast),
    .mode    (mode),
    .btn_raw (btn_raw),
    .cpu_en  (cpu_en),
    .step_cnt(step_cnt),
    .btn_db  (btn_db)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected cpu_en, compare after the edge.
  task automatic tick(input string tag, input logic c, input logic s, input logic f,
                      input logic [1:0] m, input logic b, input logic e);
    logic exp_en;
    clr     = c;
    en_slow = s;
    en_fast = f;
    mode    = m;
    btn_raw = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0b expected entry", tag, cpu_en);
    end else begin
      exp_en = exp_q.pop_front();
      check(tag, {3'b000, cpu_en}, {3'b000, exp_en});
    end
  endtask

  initial begin
    clr = 1'b1; en_slow = 1'b0; en_fast = 1'b0; mode = 2'b00; btn_raw = 1'b0;

    // Reset state
    tick("rst_en", 1, 0, 0, 2'b00, 0, 0);
    tick("rst_en", 1, 0, 0, 2'b00, 0, 0);
    check("rst_cnt", step_cnt, 4'd0);
    check("rst_db", {3'b000, btn_db}, 4'd0);

    // Slow mode: en_slow at 10 and 30, en_fast every third cycle is ignored
    for (int i = 0; i < 40; i++) begin
      tick("slow_en", 0, (i == 10) || (i == 30), (i % 3) == 0, 2'b00, 0, (i == 10) || (i == 30));
    end
    check("slow_cnt", step_cnt, 4'd2);

    // Mode switch slow->fast coincident with en_slow: dropped
    tick("sw_drop", 0, 1, 0, 2'b01, 0, 0);
    tick("sw_idle", 0, 0, 0, 2'b01, 0, 0);
    tick("sw_idle", 0, 0, 0, 2'b01, 0, 0);
    tick("sw_slow_ign", 0, 1, 0, 2'b01, 0, 0);
    tick("sw_fast", 0, 0, 1, 2'b01, 0, 1);
    tick("sw_idle", 0, 0, 0, 2'b01, 0, 0);
    check("sw_cnt", step_cnt, 4'd3);

    // Wrap: fresh count, 16 back-to-back fast pulses wrap to 0, one more gives 1
    tick("wrap_clr", 1, 0, 1, 2'b01, 0, 0);
    check("wrap_clr_cnt", step_cnt, 4'd0);
    tick("wrap_chg", 0, 0, 1, 2'b01, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick("wrap_en", 0, 0, 1, 2'b01, 0, 1);
    end
    tick("wrap_idle", 0, 0, 0, 2'b01, 0, 0);
    check("wrap_cnt0", step_cnt, 4'd0);
    tick("wrap_en17", 0, 0, 1, 2'b01, 0, 1);
    tick("wrap_idle", 0, 0, 0, 2'b01, 0, 0);
    check("wrap_cnt1", step_cnt, 4'd1);

    // Halt with every source active; the button still debounces
    for (int i = 0; i < 50; i++) begin
      tick("halt_en", 0, 1, 1, 2'b11, i < 30, 0);
      if (i == 29) check("halt_db_hi", {3'b000, btn_db}, 4'd1);
    end
    check("halt_cnt", step_cnt, 4'd1);
    check("halt_db_lo", {3'b000, btn_db}, 4'd0);

    // Manual: bounce then hold gives one pulse 6 cycles after the final rise
    tick("man_chg", 0, 0, 0, 2'b10, 0, 0);
    tick("man_idle", 0, 0, 0, 2'b10, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick("man_bounce", 0, 0, 0, 2'b10, (i % 2) == 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      tick("man_hold", 0, 1, 1, 2'b10, 1, i == 6);
    end
    check("man_db_hi", {3'b000, btn_db}, 4'd1);
    check("man_cnt", step_cnt, 4'd2);
    for (int i = 0; i < 20; i++) begin
      tick("man_rel", 0, 0, 0, 2'b10, 0, 0);
    end
    check("man_db_lo", {3'b000, btn_db}, 4'd0);
    check("man_cnt_rel", step_cnt, 4'd2);

    // Reset during PRESS_CHK with the button held: re-qualified from IDLE
    for (int i = 0; i < 3; i++) begin
      tick("mrst_hold", 0, 0, 0, 2'b10, 1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      tick("mrst_clr_en", 1, 1, 1, 2'b10, 1, 0);
      check("mrst_clr_cnt", step_cnt, 4'd0);
      check("mrst_clr_db", {3'b000, btn_db}, 4'd0);
    end
    for (int j = 0; j < 12; j++) begin
      tick("mrst_after", 0, 0, 0, 2'b10, 1, j == 6);
    end
    check("mrst_cnt", step_cnt, 4'd1);
    check("mrst_db", {3'b000, btn_db}, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
